mux_ula_pipe: RTL

MUX_ULA_PIPE -- requirements
Module: mux_ula_pipe

---
 rtl/mux_ula_pipe.sv | 115 +++++++++++
 1 files changed

// File: rtl/mux_ula_pipe.sv
// mux_ula_pipe: channel multiplexer with ALU-opcode override and a one-entry
// registered output stage using a valid/ready handshake.
//
// Parameters
//   W       channel and output width
//   N       number of input channels (N >= 2)
//   OPW     ula_op width
//   OVR_OP  ula_op code that forces OVR_VAL onto the output
//   OVR_VAL value driven on override
//   HOLD    accepted transfers after an override opcode that are also forced
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high reset
//   entrada        packed channels, channel k at bits [k*W +: W]
//   sel            channel select ($clog2(N) bits)
//   ula_op         ALU opcode
//   in_valid       input transfer offered
//   in_ready       block can accept an input transfer (combinational)
//   saida          registered selected value
//   out_valid      saida holds valid data
//   out_ready      consumer takes saida
//   override_ativo current saida came from override
//   sel_erro       current saida came from a select with sel >= N
module mux_ula_pipe #(
  parameter int             W       = 3,
  parameter int             N       = 2,
  parameter int             OPW     = 3,
  parameter logic [OPW-1:0] OVR_OP  = 3'b101,
  parameter logic [W-1:0]   OVR_VAL = 3'b101,
  parameter int             HOLD    = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N*W-1:0]       entrada,
  input  logic [$clog2(N)-1:0] sel,
  input  logic [OPW-1:0]       ula_op,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [W-1:0]         saida,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 override_ativo,
  output logic                 sel_erro
);

  localparam int SELW = $clog2(N);
  // Counter must hold the value HOLD; keep at least one bit when HOLD = 0.
  localparam int HCW  = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

  logic           accept;
  logic           is_ovr_op;
  logic           forced;
  logic           sel_ok;
  logic [W-1:0]   chan;
  logic [W-1:0]   nxt_data;
  logic [HCW-1:0] hold_cnt;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign is_ovr_op = (ula_op == OVR_OP);
  assign forced    = is_ovr_op || (hold_cnt != '0);

  // Scan the channels rather than indexing by sel, so a select >= N never
  // produces an out-of-range part-select; it simply leaves sel_ok low.
  always_comb begin
    chan   = '0;
    sel_ok = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        chan   = entrada[k*W +: W];
        sel_ok = 1'b1;
      end
    end
  end

  always_comb begin
    nxt_data = '0;
    if (forced) begin
      nxt_data = OVR_VAL;
    end else if (sel_ok) begin
      nxt_data = chan;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      saida          <= '0;
      out_valid      <= 1'b0;
      override_ativo <= 1'b0;
      sel_erro       <= 1'b0;
    end else if (accept) begin
      saida          <= nxt_data;
      out_valid      <= 1'b1;
      override_ativo <= forced;
      sel_erro       <= !forced && !sel_ok;
    end else if (out_ready) begin
      out_valid      <= 1'b0;
    end
  end

  // An override opcode reloads the count instead of adding to it.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (accept) begin
      if (is_ovr_op) begin
        hold_cnt <= HCW'(HOLD);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

endmodule
